// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo responder: FSM state types, framing constants, divider helper.
// UART_ECHO_PARITY_EN adds the even-parity states used for 8E1 framing.
package uart_pkg;

    localparam int UART_OS_RATE   = 16;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_ECHO_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_ECHO_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic int os_div(input int clk_hz, input int baud);
        return clk_hz / (baud * UART_OS_RATE);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Down-counter tick generator: one-clock tick every DIV clocks, reloaded by restart.
module uart_baud_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= RELOAD;
        end else if (restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_echo_responder.sv
// UART echo endpoint: 16x-oversampled receiver, small byte FIFO, transmitter replaying accepted bytes.
// Defining UART_ECHO_PARITY_EN switches both directions to 8E1 framing.
//
// state     | meaning
// RX_IDLE   | waiting for a synchronised falling edge
// RX_START  | validating the start bit at 8 os ticks
// RX_DATA   | sampling 8 data bits, LSB first
// RX_PARITY | sampling the even-parity bit
// RX_STOP   | sampling the stop bit, then accept or reject
// RX_BREAK  | bad frame, waiting for the line to return high
// TX_IDLE   | waiting for a FIFO byte with tx_en set
// TX_START  | driving the start bit
// TX_DATA   | driving 8 data bits, LSB first
// TX_PARITY | driving the even-parity bit
// TX_STOP   | driving the stop bit, may reload straight into TX_START
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       tx_en,
    output logic       tx,
    output logic [7:0] dataout,
    output logic       rx_done,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int OS_DIV   = os_div(CLK_FREQ, BAUD);
    localparam int BIT_CLKS = UART_OS_RATE * OS_DIV;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] OS_MID   = 4'(UART_OS_RATE / 2 - 1);
    localparam logic [3:0] OS_LAST  = 4'(UART_OS_RATE - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic rx_meta, rx_s, rx_prev, rx_fall;
    rx_state_t rx_state, rx_state_next;
    logic [3:0] os_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic os_tick, rx_sample, rx_stop_ok, rx_accept, rx_reject;

    tx_state_t tx_state, tx_state_next;
    logic [7:0] tx_shift;
    logic [2:0] tx_bit;
    logic tx_tick, tx_load, tx_line;

    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic fifo_empty, fifo_full, fifo_push, fifo_drop;
    logic [7:0] fifo_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end
    assign rx_fall = rx_prev & ~rx_s;

    // Held in restart while idle so the first tick lands OS_DIV clocks after the edge.
    uart_baud_gen #(.DIV(OS_DIV)) u_rx_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (rx_state == RX_IDLE),
        .tick    (os_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (rx_fall) rx_state_next = RX_START;
            RX_START:  if (os_tick && os_cnt == OS_MID) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_ECHO_PARITY_EN
            RX_DATA:   if (rx_sample && rx_bit == BIT_LAST) rx_state_next = RX_PARITY;
            RX_PARITY: if (rx_sample) rx_state_next = RX_STOP;
`else
            RX_DATA:   if (rx_sample && rx_bit == BIT_LAST) rx_state_next = RX_STOP;
`endif
            RX_STOP:   if (rx_sample) rx_state_next = rx_stop_ok ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (rx_s) rx_state_next = RX_IDLE;
            default:   rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_sample = os_tick && (os_cnt == OS_LAST);
        rx_accept = 1'b0;
        rx_reject = 1'b0;
        if (rx_state == RX_STOP && rx_sample) begin
            rx_accept = rx_stop_ok;
            rx_reject = ~rx_stop_ok;
        end
    end

`ifdef UART_ECHO_PARITY_EN
    logic rx_perr;
    assign rx_stop_ok = rx_s & ~rx_perr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  rx_perr <= 1'b0;
        else if (rx_state == RX_START)              rx_perr <= 1'b0;
        else if (rx_state == RX_PARITY && rx_sample) rx_perr <= rx_s ^ (^rx_shift);
    end
`else
    assign rx_stop_ok = rx_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || (rx_state == RX_START && os_tick && os_cnt == OS_MID))
                os_cnt <= '0;
            else if (os_tick)
                os_cnt <= os_cnt + 1'b1;
            if (rx_state == RX_START) begin
                rx_bit <= '0;
            end else if (rx_state == RX_DATA && rx_sample) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // A full FIFO still accepts when the TX side pops on the same clock.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_push  = rx_accept && (!fifo_full || tx_load);
    assign fifo_drop  = rx_accept && fifo_full && !tx_load;
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dataout   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_load)   rd_ptr <= rd_ptr + 1'b1;
            if (rx_accept) dataout <= rx_shift;
            rx_done   <= rx_accept;
            frame_err <= rx_reject;
            overflow  <= fifo_drop;
        end
    end

    uart_baud_gen #(.DIV(BIT_CLKS)) u_tx_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (tx_load),
        .tick    (tx_tick)
    );

    assign tx_load = (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_tick)) && !fifo_empty && tx_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_load) tx_state_next = TX_START;
            TX_START:  if (tx_tick) tx_state_next = TX_DATA;
`ifdef UART_ECHO_PARITY_EN
            TX_DATA:   if (tx_tick && tx_bit == BIT_LAST) tx_state_next = TX_PARITY;
            TX_PARITY: if (tx_tick) tx_state_next = TX_STOP;
`else
            TX_DATA:   if (tx_tick && tx_bit == BIT_LAST) tx_state_next = TX_STOP;
`endif
            TX_STOP:   if (tx_tick) tx_state_next = tx_load ? TX_START : TX_IDLE;
            default:   tx_state_next = TX_IDLE;
        endcase
    end

`ifdef UART_ECHO_PARITY_EN
    logic tx_par;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        tx_par <= 1'b0;
        else if (tx_load) tx_par <= ^fifo_head;
    end
`endif

    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift[0];
`ifdef UART_ECHO_PARITY_EN
            TX_PARITY: tx_line = tx_par;
`endif
            default:   tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift <= '0;
            tx_bit   <= '0;
            tx       <= 1'b1;
        end else begin
            tx <= tx_line;
            if (tx_load) begin
                tx_shift <= fifo_head;
                tx_bit   <= '0;
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 1'b1;
            end
        end
    end

    assign busy = !fifo_empty || (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder: a line driver feeds frames and a behavioural model
// queues expected bytes; independent monitors decode rx_done/dataout and the tx line.
module tb_uart_echo_responder;

    localparam int CLK_FREQ = 7_372_800;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 4;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int TICK     = BIT / 16;
    localparam int IDLE_LIM = 100 * BIT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       tx_en = 1'b1;
    logic       tx, rx_done, frame_err, overflow, busy;
    logic [7:0] dataout;

    uart_echo_responder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .tx_en     (tx_en),
        .tx        (tx),
        .dataout   (dataout),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
    } rx_exp_t;

    int          checks = 0;
    int          errors = 0;
    rx_exp_t     exp_rx[$];
    logic [7:0]  exp_tx[$];
    int unsigned tx_starts[$];
    int          held = 0;
    int          ferr_exp = 0;
    int          ferr_seen = 0;
    bit          tx_abort = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // Expected outcome follows the frame rules: a good frame is echoed unless it arrives
    // while tx_en is low and DEPTH bytes are already waiting.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip, input int gap);
        rx_exp_t e;
        logic    good;
`ifdef UART_ECHO_PARITY_EN
        good = stop_bit && !par_flip;
`else
        good = stop_bit;
`endif
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_ECHO_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (BIT) @(negedge clk);
`endif
        if (good) begin
            e.data = b;
            e.ovf  = 1'b0;
            if (!tx_en) begin
                e.ovf = (held >= DEPTH);
                if (!e.ovf) begin
                    held++;
                    exp_tx.push_back(b);
                end
            end else begin
                exp_tx.push_back(b);
            end
            exp_rx.push_back(e);
        end else begin
            ferr_exp++;
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_tx.size() != 0 || exp_rx.size() != 0) && n < IDLE_LIM) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, (n < IDLE_LIM), 1);
    endtask

    always @(posedge reset) tx_abort = 1;

    initial begin : rx_mon
        rx_exp_t e;
        forever begin
            @(negedge clk);
            if (rx_done === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected actual %02h required no rx_done", dataout);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_data", dataout, e.data);
                    check("rx_overflow", overflow, e.ovf);
                end
            end else if (overflow === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL overflow_alone actual 1 required 0");
            end
            if (frame_err === 1'b1) ferr_seen++;
        end
    end

    initial begin : tx_mon
        logic [7:0]  got, want;
        logic        start_b, stop_b;
        int unsigned t0;
`ifdef UART_ECHO_PARITY_EN
        logic        par_b;
`endif
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                t0 = cyc;
                tx_abort = 0;
                repeat (BIT / 2 - 1) @(negedge clk);
                start_b = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    got[i] = tx;
                end
`ifdef UART_ECHO_PARITY_EN
                repeat (BIT) @(negedge clk);
                par_b = tx;
`endif
                repeat (BIT) @(negedge clk);
                stop_b = tx;
                if (!tx_abort) begin
                    tx_starts.push_back(t0);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected actual %02h required no frame", got);
                    end else begin
                        want = exp_tx.pop_front();
                        check("tx_start", start_b, 0);
                        check("tx_data", got, want);
`ifdef UART_ECHO_PARITY_EN
                        check("tx_parity", par_b, ^want);
`endif
                        check("tx_stop", stop_b, 1);
                        check("tx_busy_in_stop", busy, 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual timeout required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n_low;
        int prev_starts;
        logic [7:0] b;
        logic stop_bit;
        int gap;

        repeat (5) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_dataout", dataout, 8'h00);
        check("rst_rx_done", rx_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (4 * BIT) @(negedge clk);

        // 0xAB: single echo and rx_done-to-start latency
        fork
            send_frame(8'hAB, 1'b1, 1'b0, 2 * BIT);
            begin : lat
                int n;
                n = 0;
                while (rx_done !== 1'b1 && n < 20 * BIT) begin
                    @(negedge clk);
                    n++;
                end
                check("ab_rx_done_seen", rx_done, 1);
                n = 0;
                while (tx !== 1'b0 && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                check("ab_echo_latency_le2", (n <= 2), 1);
            end
        join
        wait_idle("ab");
        check("ab_tx_idle_high", tx, 1);

        // Start-bit glitch of 5 os ticks
        rx = 1'b0;
        repeat (5 * TICK) @(negedge clk);
        rx = 1'b1;
        n_low = 0;
        repeat (20 * BIT) begin
            @(negedge clk);
            if (tx === 1'b0) n_low++;
        end
        check("glitch_tx_high", n_low, 0);
        check("glitch_no_frame_err", ferr_seen, ferr_exp);
        check("glitch_not_busy", busy, 0);

        // Bad stop bit, then a clean frame
        send_frame(8'h55, 1'b0, 1'b0, 2 * BIT);
        check("ferr_55", ferr_seen, ferr_exp);
        send_frame(8'h3C, 1'b1, 1'b0, 2 * BIT);
        wait_idle("ferr_3c");

        // Hold off TX, overfill the FIFO, then release
        tx_en = 1'b0;
        held = 0;
        prev_starts = tx_starts.size();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
        repeat (BIT) @(negedge clk);
        check("hold_dataout", dataout, 8'h05);
        check("hold_busy", busy, 1);
        check("hold_tx_high", tx, 1);
        check("hold_no_frames", tx_starts.size(), prev_starts);
        tx_starts.delete();
        tx_en = 1'b1;
        held = 0;
        wait_idle("release");
        check("release_frames", tx_starts.size(), 4);
        if (tx_starts.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("b2b_gap", ((tx_starts[i] - tx_starts[i-1]) >= 10 * BIT) &&
                                 ((tx_starts[i] - tx_starts[i-1]) <= 10 * BIT + 1), 1);
            end
        end

        // Reset in the middle of echoing 0xF0
        send_frame(8'hF0, 1'b1, 1'b0, 0);
        repeat (3 * BIT) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("reset_tx_async", tx, 1);
        check("reset_busy_async", busy, 0);
        exp_tx.delete();
        repeat (3) @(negedge clk);
        check("reset_dataout", dataout, 8'h00);
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0, BIT);
        wait_idle("post_reset");

`ifdef UART_ECHO_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, BIT);
        wait_idle("par_good");
        send_frame(8'h07, 1'b1, 1'b1, 2 * BIT);
        wait_idle("par_bad");
        check("par_ferr", ferr_seen, ferr_exp);
`endif

        // Random bytes, random gaps, occasional bad stop bit
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 4) != 0);
            gap = stop_bit ? int'($urandom_range(0, 4 * BIT)) : BIT + int'($urandom_range(0, BIT));
            send_frame(b, stop_bit, 1'b0, gap);
        end
        wait_idle("random");

        repeat (2 * BIT) @(negedge clk);
        check("final_ferr_count", ferr_seen, ferr_exp);
        check("final_rx_queue", exp_rx.size(), 0);
        check("final_tx_queue", exp_tx.size(), 0);
        check("final_tx_high", tx, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
